// File: rtl/comp4_sort_ctrl_if.sv
// Valid/ready word stream used for both the load and unload sides.
// master drives valid/data, slave drives ready.
interface comp4_sort_ctrl_if #(
  parameter int W = 4
);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );
endinterface

// File: rtl/comp4_sort_ctrl.sv
// Bubble-sort sequencer: loads DEPTH words, sorts them in place with one
// shared comparator (one compare per cycle), then unloads smallest first.
// Ports: clk_i, rst_i (async, active-high); in_if (slave: valid/ready/data);
// out_if (master: valid/ready/data); busy_o (sorting); done_o (pulse on
// first unload cycle); swap_cnt_o (swaps this frame, saturating at 255).
module comp4_sort_ctrl #(
  parameter int W     = 4,
  parameter int DEPTH = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  comp4_sort_ctrl_if.slave    in_if,
  comp4_sort_ctrl_if.master   out_if,
  output logic                busy_o,
  output logic                done_o,
  output logic [7:0]          swap_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [AW-1:0] JEND = AW'(DEPTH - 2);

  typedef enum logic [1:0] {
    S_LOAD,
    S_SORT,
    S_UNLOAD
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  bank_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q, j_q, pass_q;
  logic          flag_q;
  logic [7:0]    cnt_q;
  logic          done_q;

  logic [AW-1:0] jn;
  logic [W-1:0]  op_a, op_b;
  logic          gt;
  logic          in_acc, out_xfer;
  logic          sort_end;

  assign jn       = j_q + 1'b1;
  assign op_a     = bank_q[j_q];
  assign op_b     = bank_q[jn];
  assign gt       = op_a > op_b;
  assign in_acc   = in_if.valid & in_if.ready;
  assign out_xfer = out_if.valid & out_if.ready;

  // Last compare of a pass: finish when this pass made no swap
  // (including the one happening now) or the pass budget is spent.
  assign sort_end = (j_q == JEND) &&
                    (!(flag_q | gt) || (pass_q == JEND));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_LOAD;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_LOAD:
        if (in_acc && wr_q == LAST) state_d = S_SORT;
      S_SORT:
        if (sort_end) state_d = S_UNLOAD;
      S_UNLOAD:
        if (out_xfer && rd_q == LAST) state_d = S_LOAD;
      default: state_d = S_LOAD;
    endcase
  end

  always_comb begin
    in_if.ready  = (state_q == S_LOAD);
    out_if.valid = (state_q == S_UNLOAD);
    busy_o       = (state_q == S_SORT);
    out_if.data  = out_if.valid ? bank_q[rd_q] : '0;
    done_o       = done_q;
    swap_cnt_o   = cnt_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) bank_q[i] <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      j_q    <= '0;
      pass_q <= '0;
      flag_q <= 1'b0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state_q == S_SORT) && sort_end;
      unique case (state_q)
        S_LOAD: begin
          if (in_acc) begin
            bank_q[wr_q] <= in_if.data;
            wr_q <= (wr_q == LAST) ? '0 : wr_q + 1'b1;
            if (wr_q == '0) cnt_q <= '0;
          end
        end
        S_SORT: begin
          if (gt) begin
            bank_q[j_q] <= op_b;
            bank_q[jn]  <= op_a;
            flag_q      <= 1'b1;
            if (cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
          end
          if (j_q == JEND) begin
            j_q    <= '0;
            flag_q <= 1'b0;
            pass_q <= sort_end ? '0 : pass_q + 1'b1;
          end else begin
            j_q <= jn;
          end
        end
        S_UNLOAD: begin
          if (out_xfer)
            rd_q <= (rd_q == LAST) ? '0 : rd_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
